// File: rtl/pcm_mm_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pcm_mm_scheduler
// Description : Responder side of the PCM main-memory schedule/resolved
//               handshake. Each rising edge of schedule queues one request
//               {addr, cpu_write, cpu_in}. Requests are issued to the PCM
//               array in arrival order with fixed read/write latencies, and
//               each completion pulses resolved with the returned data.
// Ports       : clk, reset (sync, active-low)
//               schedule/addr/cpu_write/cpu_in  - request side inputs
//               resolved/data_in                - completion pulse and data
//               busy/full/overflow              - queue and engine status
//               mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - PCM device port
// Revision    : 1.0 - initial release
// ============================================================================
module pcm_mm_scheduler #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 4,
  parameter int READ_LAT  = 4,
  parameter int WRITE_LAT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              schedule,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_in,
  output logic              resolved,
  output logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              full,
  output logic              overflow,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam int ENT_W   = ADDR_W + 1 + DATA_W;

  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] RD_LOAD    = CNT_W'(READ_LAT);
  localparam logic [CNT_W-1:0] WR_LOAD    = CNT_W'(WRITE_LAT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t            state;
  logic              sched_prev;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;
  logic [CNT_W-1:0]  lat_cnt;
  logic [ENT_W-1:0]  fifo_mem [DEPTH];

  logic              sched_edge;
  logic              push;
  logic              pop;
  logic [ENT_W-1:0]  head;

  assign sched_edge = schedule & ~sched_prev;
  // full reflects the count before any same-cycle pop, so an edge arriving
  // while full is dropped even if the head leaves on that very cycle.
  assign full       = (count == FULL_COUNT);
  assign push       = sched_edge & ~full;
  assign pop        = (state == IDLE) && (count != '0);
  assign head       = fifo_mem[rd_ptr];
  assign busy       = (count != '0) || (state != IDLE);

  // Queue storage needs no reset: entries are only read once count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {addr, cpu_write, cpu_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      sched_prev <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      lat_cnt    <= '0;
      overflow   <= 1'b0;
      resolved   <= 1'b0;
      data_in    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      sched_prev <= schedule;

      if (sched_edge && full) begin
        overflow <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase

      mem_en   <= 1'b0;
      resolved <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            mem_en                          <= 1'b1;
            {mem_addr, mem_we, mem_wdata}   <= head;
            state                           <= ISSUE;
          end
        end
        ISSUE: begin
          lat_cnt <= mem_we ? WR_LOAD : RD_LOAD;
          state   <= WAIT;
        end
        WAIT: begin
          // Last wait cycle: read data is valid now, completion shows next cycle.
          if (lat_cnt == CNT_W'(1)) begin
            data_in  <= mem_we ? mem_wdata : mem_rdata;
            resolved <= 1'b1;
            state    <= RESPOND;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        RESPOND: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pcm_mm_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcm_mm_scheduler
// Description : Cycle-accurate checker for pcm_mm_scheduler. A transaction
//               model (request queue + job start/finish cycle arithmetic)
//               predicts every output on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcm_mm_scheduler;

  localparam int ADDR_W    = 20;
  localparam int DATA_W    = 16;
  localparam int DEPTH     = 4;
  localparam int READ_LAT  = 4;
  localparam int WRITE_LAT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              schedule;
  logic [ADDR_W-1:0] addr;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_in;
  logic              resolved;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              full;
  logic              overflow;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  pcm_mm_scheduler #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)
  ) dut (
    .clk(clk), .reset(reset), .schedule(schedule), .addr(addr),
    .cpu_write(cpu_write), .cpu_in(cpu_in), .resolved(resolved),
    .data_in(data_in), .busy(busy), .full(full), .overflow(overflow),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic              w;
    logic [DATA_W-1:0] d;
  } req_t;

  // Transaction model
  req_t              q[$];
  req_t              m_job;
  int                cyc = 0;
  bit                m_prev, m_active, m_ovf, m_in_reset;
  int                m_start_c, m_res_c, m_next_ok;
  logic [DATA_W-1:0] m_data;
  bit                rand_rdata = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Apply the rules of one clock edge to the transaction model.
  task automatic model_edge();
    bit edge_s;
    int size0;
    cyc++;
    if (!reset) begin
      q.delete();
      m_prev     = 1'b0;
      m_active   = 1'b0;
      m_ovf      = 1'b0;
      m_data     = '0;
      m_next_ok  = 0;
      m_start_c  = -10;
      m_res_c    = -10;
      m_in_reset = 1'b1;
      return;
    end
    m_in_reset = 1'b0;
    edge_s = schedule && !m_prev;
    m_prev = schedule;
    size0  = q.size();
    if (m_active && cyc > m_res_c) m_active = 1'b0;
    if (!m_active && q.size() > 0 && cyc >= m_next_ok) begin
      m_job     = q.pop_front();
      m_active  = 1'b1;
      m_start_c = cyc;
      m_res_c   = cyc + (m_job.w ? WRITE_LAT : READ_LAT) + 1;
      m_next_ok = m_res_c + 2;
    end
    if (m_active && cyc == m_res_c) m_data = m_job.w ? m_job.d : mem_rdata;
    if (edge_s) begin
      if (size0 == DEPTH) m_ovf = 1'b1;
      else q.push_back({addr, cpu_write, cpu_in});
    end
  endtask

  task automatic check_outputs();
    chk("resolved", 32'(resolved), 32'(m_active && cyc == m_res_c));
    chk("mem_en",   32'(mem_en),   32'(m_active && cyc == m_start_c));
    chk("data_in",  32'(data_in),  32'(m_data));
    chk("busy",     32'(busy),     32'(q.size() != 0 || m_active));
    chk("full",     32'(full),     32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_in_reset) begin
      chk("rst_mem_we",    32'(mem_we),    32'(0));
      chk("rst_mem_addr",  32'(mem_addr),  32'(0));
      chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    end else if (m_active) begin
      chk("mem_we",    32'(mem_we),    32'(m_job.w));
      chk("mem_addr",  32'(mem_addr),  32'(m_job.a));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_job.d));
    end
  endtask

  task automatic tick();
    if (rand_rdata) mem_rdata = DATA_W'($urandom);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  initial begin
    reset     = 1'b0;
    schedule  = 1'b0;
    addr      = '0;
    cpu_write = 1'b0;
    cpu_in    = '0;
    mem_rdata = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Single read from an idle engine
    addr = 20'h00010; cpu_write = 1'b0; mem_rdata = 16'hBEEF; schedule = 1'b1;
    repeat (10) tick();
    schedule = 1'b0;
    repeat (2) tick();

    // Single write
    addr = 20'h00020; cpu_write = 1'b1; cpu_in = 16'h1234; schedule = 1'b1;
    repeat (20) tick();
    schedule = 1'b0;
    tick();

    // Five edges while a write is in flight: four queue, fifth overflows
    rand_rdata = 1'b1;
    addr = 20'h00030; cpu_write = 1'b1; cpu_in = 16'hAAAA; schedule = 1'b1;
    tick();
    schedule = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      schedule  = 1'b1;
      addr      = 20'h00100 + 20'(i);
      cpu_write = i[0];
      cpu_in    = DATA_W'($urandom);
      tick();
      schedule = 1'b0;
      tick();
    end
    repeat (120) tick();

    // Read then write queued back-to-back
    addr = 20'h00040; cpu_write = 1'b0; schedule = 1'b1;
    tick();
    schedule = 1'b0;
    tick();
    addr = 20'h00050; cpu_write = 1'b1; cpu_in = 16'h5A5A; schedule = 1'b1;
    tick();
    schedule = 1'b0;
    repeat (40) tick();

    // Reset during the wait of a write, schedule held through reset
    addr = 20'h00060; cpu_write = 1'b1; cpu_in = 16'hC0DE; schedule = 1'b1;
    repeat (6) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (25) tick();
    schedule = 1'b0;
    repeat (2) tick();

    // Schedule held high for 40 cycles: one request only
    addr = 20'h00070; cpu_write = 1'b0; schedule = 1'b1;
    repeat (40) tick();
    schedule = 1'b0;
    repeat (3) tick();

    // Random traffic with occasional resets
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 2) == 0) schedule = ~schedule;
      addr      = ADDR_W'($urandom);
      cpu_write = 1'($urandom);
      cpu_in    = DATA_W'($urandom);
      reset     = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset = 1'b1;
    schedule = 1'b0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
